edabk_receiver: RTL

UART receive block for the edabk_uart_transceiver: it is the counterpart of the transmitter datapath. It oversamples the serial line on the baud clock (CLK_DIV bclks per bit) and detects the start bit. It then samples each data bit at mid-bit, LSB first, and checks the stop bit. Each received word is presented in a holding register with a valid/acknowledge handshake, plus framing and overrun status.

---
 rtl/edabk_receiver.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/edabk_receiver.sv
//------------------------------------------------------------------------------
// Module      : edabk_receiver
// Description : UART receive path. Oversamples rx_in on bclk (CLK_DIV bclks
//               per bit), qualifies the start bit at its midpoint, samples
//               data bits LSB first and checks the stop bit. Each word is held
//               in rx_data with a valid/ack handshake plus framing and
//               overrun status.
// Options     : EDABK_RX_PARITY_EN - adds an even-parity bit after the data
//               bits and the parity_err output.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef CFG_CLK_DIV
`define CFG_CLK_DIV 16
`endif
`ifndef CFG_DATA_WIDTH
`define CFG_DATA_WIDTH 8
`endif

module edabk_receiver #(
  parameter int CLK_DIV     = `CFG_CLK_DIV,
  parameter int DATA_WIDTH  = `CFG_DATA_WIDTH,
  parameter int COUNT_WIDTH = $clog2(CLK_DIV)
) (
  input  logic                  bclk,
  input  logic                  reset,
  input  logic                  rx_in,
  input  logic                  rx_ack,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  frame_err,
  output logic                  overrun_err,
`ifdef EDABK_RX_PARITY_EN
  output logic                  parity_err,
`endif
  output logic                  busy
);

  localparam int IDX_WIDTH = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [COUNT_WIDTH-1:0] c_cnt_mid  = COUNT_WIDTH'(CLK_DIV / 2 - 1);
  localparam logic [COUNT_WIDTH-1:0] c_cnt_last = COUNT_WIDTH'(CLK_DIV - 1);
  localparam logic [IDX_WIDTH-1:0]   c_idx_last = IDX_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  // Synchronizer and edge-detect history; idle line level is 1.
  logic                   r_sync1;
  logic                   r_sync2;
  logic                   r_rx_prev;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] w_count_next;
  logic [IDX_WIDTH-1:0]   r_bit_idx;
  logic [IDX_WIDTH-1:0]   w_idx_next;

  logic                   w_shift_en;
  logic                   w_load;

  logic [DATA_WIDTH-1:0]  r_shift;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;
  logic                   r_ferr;
  logic                   r_overrun;

`ifdef EDABK_RX_PARITY_EN
  logic                   w_par_cap;
  logic                   r_par_bit;
  logic                   r_perr;
`endif

  // Two-flop synchronizer plus a delayed copy used to require a 1->0 edge.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx_in;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  // FSM state, bit-time counter and data bit index registers.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_count   <= '0;
      r_bit_idx <= '0;
    end else begin
      r_state   <= w_state_next;
      r_count   <= w_count_next;
      r_bit_idx <= w_idx_next;
    end
  end

  // Next-state logic: counter restarts on every state entry, sample strobes.
  always_comb begin
    w_state_next = r_state;
    w_count_next = (r_count == c_cnt_last) ? '0 : r_count + 1'b1;
    w_idx_next   = r_bit_idx;
    w_shift_en   = 1'b0;
    w_load       = 1'b0;
`ifdef EDABK_RX_PARITY_EN
    w_par_cap    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        w_count_next = '0;
        // A line held low after a break must rise and fall again first.
        if (!r_sync2 && r_rx_prev) begin
          w_state_next = ST_START;
        end
      end
      ST_START: begin
        if (r_count == c_cnt_mid) begin
          w_count_next = '0;
          w_idx_next   = '0;
          // High at mid start bit means a glitch, not a frame.
          w_state_next = r_sync2 ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_count == c_cnt_last) begin
          w_shift_en   = 1'b1;
          w_count_next = '0;
          if (r_bit_idx == c_idx_last) begin
            w_idx_next   = '0;
`ifdef EDABK_RX_PARITY_EN
            w_state_next = ST_PARITY;
`else
            w_state_next = ST_STOP;
`endif
          end else begin
            w_idx_next = r_bit_idx + 1'b1;
          end
        end
      end
`ifdef EDABK_RX_PARITY_EN
      ST_PARITY: begin
        if (r_count == c_cnt_last) begin
          w_par_cap    = 1'b1;
          w_count_next = '0;
          w_state_next = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        // Leave at mid stop bit so a back-to-back start edge is not missed.
        if (r_count == c_cnt_last) begin
          w_load       = 1'b1;
          w_count_next = '0;
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_count_next = '0;
        w_idx_next   = '0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Shift register (LSB arrives first, enters at MSB) and holding register.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift <= {r_sync2, r_shift[DATA_WIDTH-1:1]};
      end
      // A completing word takes priority over a same-cycle acknowledge.
      if (w_load) begin
        r_data    <= r_shift;
        r_valid   <= 1'b1;
        r_ferr    <= ~r_sync2;
        r_overrun <= r_overrun | r_valid;
      end else if (rx_ack && r_valid) begin
        r_valid   <= 1'b0;
        r_overrun <= 1'b0;
      end
    end
  end

`ifdef EDABK_RX_PARITY_EN
  // Parity sample capture and even-parity check loaded with each word.
  always_ff @(posedge bclk or posedge reset) begin
    if (reset) begin
      r_par_bit <= 1'b0;
      r_perr    <= 1'b0;
    end else begin
      if (w_par_cap) begin
        r_par_bit <= r_sync2;
      end
      if (w_load) begin
        r_perr <= (^r_shift) ^ r_par_bit;
      end
    end
  end

  assign parity_err = r_perr;
`endif

  assign rx_data     = r_data;
  assign rx_valid    = r_valid;
  assign frame_err   = r_ferr;
  assign overrun_err = r_overrun;
  assign busy        = (r_state != ST_IDLE);

endmodule

`default_nettype wire
